// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC channel.
package tdc_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} tdc_state_t;

  // Depth of the tap synchroniser; detection happens on the last stage.
  localparam int unsigned SAMPLE_STAGES = 2;

  // Widest delay line the popcount helper handles.
  localparam int unsigned MAX_TAPS = 1024;

  // Count of ones in a thermometer code (zero-extended to MAX_TAPS).
  function automatic int unsigned popcount(input logic [MAX_TAPS-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_TAPS; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tdc_channel_therm2bin.sv
// Thermometer-to-binary encoder: optional bubble filter plus popcount.
// Build option: TDC_BUBBLE_FILTER_EN enables the 3-tap majority filter.
module tdc_therm2bin
  import tdc_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0]           code,
  output logic [$clog2(N+1)-1:0] fine,
  output logic                   hit
);

  localparam int FW = $clog2(N+1);

  logic [N-1:0] c;

`ifdef TDC_BUBBLE_FILTER_EN
  // Pad with 1 below tap 0 and 0 above tap N-1 so edge taps see an ideal neighbour.
  logic [N+1:0] ext;
  assign ext = {1'b0, code, 1'b1};

  // Majority of each tap and its two neighbours removes single-tap bubbles.
  always_comb begin
    c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
    end
  end
`else
  assign c = code;
`endif

  // Ones count and detection flag of the (possibly filtered) code.
  always_comb begin
    fine = FW'(popcount({{(MAX_TAPS-N){1'b0}}, c}));
    hit  = |c;
  end

endmodule

// File: rtl/tdc_channel.sv
// Single-channel TDC: delay line, two-stage tap sampler, encoder, coarse counter.
// Build option: TDC_BUBBLE_FILTER_EN (bubble filter inside tdc_therm2bin).

// Delay line: hit ripples through a carry chain; each carry is one tap.
module delay_line #(
  parameter int N       = 64,
  parameter     DL_TYPE = "RCA"
) (
  input  logic         hit,
  output logic [N-1:0] taps
);

  generate
    if (DL_TYPE == "RCA") begin : g_rca
      // Adder with A=all ones, B=0: every stage propagates its carry-in.
      logic [N:0] carry;
      assign carry[0] = hit;
      for (genvar i = 0; i < N; i++) begin : g_cell
        assign carry[i+1] = (1'b1 & carry[i]) | (1'b0 & 1'b1);
      end
      assign taps = carry[N:1];
    end else begin : g_none
      assign taps = '0;
    end
  endgenerate

endmodule

module tdc_channel
  import tdc_pkg::*;
#(
  parameter int N       = 64,
  parameter     DL_TYPE = "RCA",
  parameter int CW      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm_i,
  input  logic                   hit_i,
  input  logic                   out_ready_i,
  output logic                   out_valid_o,
  output logic [CW-1:0]          coarse_o,
  output logic [$clog2(N+1)-1:0] fine_o,
  output logic                   overflow_o,
  output logic                   busy_o
);

  localparam int FW = $clog2(N+1);

  tdc_state_t   state, state_next;
  logic [N-1:0] taps;
  logic [N-1:0] smp [SAMPLE_STAGES];
  logic [N-1:0] s2;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fine_w;
  logic          hit_seen;
  logic          cnt_clr, cnt_inc, load_hit, load_ovf, clear;

  (* keep *) delay_line #(.N(N), .DL_TYPE(DL_TYPE)) u_dl (
    .hit  (hit_i),
    .taps (taps)
  );

  assign s2 = smp[SAMPLE_STAGES-1];

  tdc_therm2bin #(.N(N)) u_enc (
    .code (s2),
    .fine (fine_w),
    .hit  (hit_seen)
  );

  assign busy_o = (state != IDLE);

  // Next-state and datapath strobes; a hit on the saturating cycle beats overflow.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    load_hit   = 1'b0;
    load_ovf   = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (arm_i && (s2 == '0)) begin
          state_next = ARMED;
          cnt_clr    = 1'b1;
        end
      end
      ARMED: begin
        if (hit_seen) begin
          load_hit   = 1'b1;
          state_next = DONE;
        end else if (cnt == '1) begin
          load_ovf   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          clear      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, sampler pipeline, coarse counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      for (int unsigned s = 0; s < SAMPLE_STAGES; s++) begin
        smp[s] <= '0;
      end
      cnt         <= '0;
      out_valid_o <= 1'b0;
      coarse_o    <= '0;
      fine_o      <= '0;
      overflow_o  <= 1'b0;
    end else begin
      state  <= state_next;
      smp[0] <= taps;
      for (int unsigned s = 1; s < SAMPLE_STAGES; s++) begin
        smp[s] <= smp[s-1];
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (load_hit) begin
        coarse_o    <= cnt;
        fine_o      <= fine_w;
        overflow_o  <= 1'b0;
        out_valid_o <= 1'b1;
      end
      if (load_ovf) begin
        coarse_o    <= '1;
        fine_o      <= '0;
        overflow_o  <= 1'b1;
        out_valid_o <= 1'b1;
      end
      if (clear) begin
        out_valid_o <= 1'b0;
        overflow_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdc_channel.sv
// Bench for tdc_channel: directed stimulus, expected results queued, monitors compare.
module tb_tdc_channel;

  localparam int N  = 64;
  localparam int FW = 7;

`ifdef TDC_BUBBLE_FILTER_EN
  localparam logic [6:0] BUBBLE_FINE = 7'd8;
`else
  localparam logic [6:0] BUBBLE_FINE = 7'd7;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          arm, hit, rdy, valid, ovf, busy;
  logic [7:0]    coarse;
  logic [FW-1:0] fine;
  logic          arm4, hit4, rdy4, valid4, ovf4, busy4;
  logic [3:0]    coarse4;
  logic [FW-1:0] fine4;

  tdc_channel #(.N(N), .DL_TYPE("RCA"), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .arm_i(arm), .hit_i(hit), .out_ready_i(rdy),
    .out_valid_o(valid), .coarse_o(coarse), .fine_o(fine),
    .overflow_o(ovf), .busy_o(busy)
  );

  tdc_channel #(.N(N), .DL_TYPE("RCA"), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .arm_i(arm4), .hit_i(hit4), .out_ready_i(rdy4),
    .out_valid_o(valid4), .coarse_o(coarse4), .fine_o(fine4),
    .overflow_o(ovf4), .busy_o(busy4)
  );

  typedef struct {
    logic [7:0] coarse;
    logic [6:0] fine;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && (q.size() != 0 || q4.size() != 0); i++) tick();
    check(name, 64'(q.size() + q4.size()), 64'd0);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_arm4();
    arm4 = 1'b1;
    tick();
    arm4 = 1'b0;
  endtask

  // Monitor for the CW=8 instance.
  always @(negedge clk) begin
    if (rst_n && valid && rdy) begin
      if (q.size() == 0) begin
        check("unexpected_result", 64'(valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("coarse", 64'(coarse), 64'(e.coarse));
        check("fine", 64'(fine), 64'(e.fine));
        check("overflow", 64'(ovf), 64'(e.ovf));
      end
    end
  end

  // Monitor for the CW=4 instance.
  always @(negedge clk) begin
    if (rst_n && valid4 && rdy4) begin
      if (q4.size() == 0) begin
        check("unexpected_result4", 64'(valid4), 64'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("coarse4", 64'(coarse4), 64'(e.coarse));
        check("fine4", 64'(fine4), 64'(e.fine));
        check("overflow4", 64'(ovf4), 64'(e.ovf));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    arm = 0; hit = 0; rdy = 1;
    arm4 = 0; hit4 = 0; rdy4 = 1;

    ticks(3);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_coarse", 64'(coarse), 64'd0);
    check("rst_fine", 64'(fine), 64'd0);
    check("rst_overflow", 64'(ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    ticks(2);

    // Basic: 20 taps high four cycles after arming -> detected at cnt=6.
    pulse_arm();
    check("basic_busy", 64'(busy), 64'd1);
    ticks(4);
    force dut.taps = 64'h0000_0000_000F_FFFF;
    q.push_back('{8'd6, 7'd20, 1'b0});
    wait_drain("basic_drain");
    release dut.taps;
    ticks(3);

    // Real delay line: hit long before sampling gives a full code (fine = N).
    pulse_arm();
    hit = 1'b1;
    q.push_back('{8'd2, 7'd64, 1'b0});
    wait_drain("full_drain");
    hit = 1'b0;
    ticks(3);

    // Backpressure: result held for 10 cycles, arm pulses ignored.
    rdy = 1'b0;
    pulse_arm();
    force dut.taps = 64'h7;
    q.push_back('{8'd2, 7'd3, 1'b0});
    for (int i = 0; i < 20 && !valid; i++) tick();
    check("bp_valid_seen", 64'(valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      arm = (i % 2 == 0);
      tick();
      check("bp_valid", 64'(valid), 64'd1);
      check("bp_coarse", 64'(coarse), 64'd2);
      check("bp_fine", 64'(fine), 64'd3);
      check("bp_busy", 64'(busy), 64'd1);
    end
    arm = 1'b1;
    rdy = 1'b1;
    tick();
    arm = 1'b0;
    check("bp_release_valid", 64'(valid), 64'd0);
    check("bp_release_idle", 64'(busy), 64'd0);
    tick();
    check("bp_arm_ignored", 64'(busy), 64'd0);
    release dut.taps;
    wait_drain("bp_drain");
    ticks(3);

    // Hit already high when armed: arm is ignored.
    hit = 1'b1;
    ticks(3);
    pulse_arm();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy || valid) seen++;
      tick();
    end
    check("hit_high_no_arm", 64'(seen), 64'd0);
    hit = 1'b0;
    ticks(3);

    // Bubble at tap 3.
    pulse_arm();
    force dut.taps = 64'h0000_0000_0000_00F7;
    q.push_back('{8'd2, BUBBLE_FINE, 1'b0});
    wait_drain("bubble_drain");
    release dut.taps;
    ticks(3);

    // CW=4 timeout: 16th ARMED cycle saturates.
    pulse_arm4();
    q4.push_back('{8'd15, 7'd0, 1'b1});
    wait_drain("timeout_drain");
    tick();
    check("timeout_ovf_cleared", 64'(ovf4), 64'd0);
    check("timeout_idle", 64'(busy4), 64'd0);
    ticks(2);

    // CW=4: hit visible exactly on the saturating cycle wins over overflow.
    pulse_arm4();
    ticks(13);
    force dut4.taps = 64'h1;
    q4.push_back('{8'd15, 7'd1, 1'b0});
    wait_drain("sat_hit_drain");
    release dut4.taps;
    ticks(3);

    // Asynchronous reset mid-measurement.
    pulse_arm();
    ticks(3);
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid", 64'(valid), 64'd0);
    check("rst_mid_coarse", 64'(coarse), 64'd0);
    check("rst_mid_fine", 64'(fine), 64'd0);
    ticks(2);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid || busy) seen++;
      tick();
    end
    check("rst_mid_no_result", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
